seg7_scan_display_n: RTL and testbench
======================================

Name: seg7_scan_display_n

Overview:
- Parametrised multiplexed 7-segment hex display driver; the next-generation display back end for the calculator datapath.
- Scans NDIG digits from a packed 4·NDIG-bit value.
- Adds over the previous driver: a double-buffered load that commits only at frame boundaries (no tearing), per-digit decimal points, leading-zero blanking, per-digit blink, selectable output polarity, and a frame tick.

Parameters:
- NDIG, 8, number of digits (1..16).
- DIV, 100000, clock cycles per digit slot (≥2); counter width $clog2(DIV).
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1).
- ACTIVE_LOW, 1, 1 = enables and segments are active-low; 0 = all display outputs are inverted to active-high.

Ports:
- clk_g  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; starts scanning; sticky until reset.
- load  in  1  pulse; captures value/dp_mask/blink_mask.
- value  in  4*NDIG  hex nibbles; nibble k drives digit k, digit 0 = least significant.
- dp_mask  in  NDIG  bit k lights the decimal point of digit k.
- blink_mask  in  NDIG  bit k makes digit k blink.
- blank_lz  in  1  level; enables leading-zero blanking.
- led_en  out  NDIG  digit enables, one-hot active.
- led_seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB.
- led_dp  out  1  decimal point.
- frame_tick  out  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- Polarity: "off" means 1 when ACTIVE_LOW=1 and 0 when ACTIVE_LOW=0. Values below are written for ACTIVE_LOW=1.
- Reset (async, rst_n=0):
  - led_en, led_seg and led_dp all off; frame_tick=0.
  - running=0, slot counter=0, digit index=0.
  - Pending and active buffers cleared to 0; pending flag=0.
  - Blink phase=0; frame counter=0.
- Reset asserted mid-scan forces these values immediately.
- IDLE → RUN:
  - start sampled high at edge E sets running; the counter starts from 0.
  - The first enable (digit 0) appears at edge E+DIV.
  - start is ignored while running.
- RUN:
  - The counter counts 0..DIV-1.
  - At the terminal count: the counter returns to 0 and the index advances; NDIG-1 wraps to 0.
  - led_en has only bit[index] active.
  - The enable, segments and dp for a slot all update on the same edge (registered together; no ghost cycle).
- Frame boundary = terminal count that selects digit 0 (including the first one after start).
- Double buffer:
  - load copies the inputs to the pending buffer and sets the pending flag.
  - At a frame boundary with the flag set: pending → active and the flag clears.
  - load coincident with a boundary: the values on the inputs that cycle are committed directly.
  - Repeated loads within one frame: the last one wins.
  - While idle: load commits to active on the next edge.
- Segment decode (a..g, 1=off):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- Leading-zero blanking (blank_lz=1):
  - Digit k>0 is blanked (all segments off) when active nibbles k..NDIG-1 are all zero.
  - Digit 0 is never blanked.
  - The decimal point follows dp_mask even on a blanked digit.
- Blink:
  - The frame counter increments per boundary; at BLINK_FRAMES-1 it wraps and the blink phase toggles.
  - In phase 1, digits with an active blink_mask bit show segments and dp off.
  - The digit enable still cycles normally during blink-off.
- frame_tick: asserted on the same edge the digit 0 enable becomes active; it is 0 while idle.

Test Plan:
- Reset and start (NDIG=4, DIV=4, value=16'h1234, load while idle; start at edge 10):
  - led_en=4'b1111 and led_seg=7'b1111111 through edge 13.
  - Edge 14: led_en=4'b1110, led_seg=7'b1001100 ('4'), frame_tick=1.
  - Then 1110→1101→1011→0111 every 4 cycles, showing 4,3,2,1, then wrap.
- Tear-free load:
  - While digit 2 is active, load 16'hABCD.
  - Digits 2 and 3 still show 2 and 1.
  - At the next frame_tick, digit 0 shows 'd' (1000010).
- Leading zeros: value=16'h0050, blank_lz=1 → digit3=1111111, digit2=1111111, digit1=0100100, digit0=0000001. With blank_lz=0, digits 3 and 2 show 0000001.
- Decimal point and blink (BLINK_FRAMES=2):
  - dp_mask=4'b0010, blink_mask=4'b0001.
  - led_dp=0 only in the digit-1 slot.
  - Digit 0 is dark during frames 2-3, lit during frames 4-5.
- Mid-scan reset: drop rst_n during slot 2 → all outputs off the same cycle. Restart with start → timing as in the reset-and-start test, active buffer=0.
- Polarity: ACTIVE_LOW=0 → reset gives led_en=0 and led_seg=0; digit 0 showing '8' gives led_en=4'b0001, led_seg=7'b1111111.

Source files
------------

// File: rtl/seg7_scan_display_n.sv
// Multiplexed NDIG-digit 7-segment hex driver with double-buffered load,
// decimal points, leading-zero blanking, blink, selectable polarity and a frame tick.
module seg7_scan_display_n #(
   parameter int NDIG         = 8,
   parameter int DIV          = 100000,
   parameter int BLINK_FRAMES = 64,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic              clk_g,
   input  logic              rst_n,
   input  logic              start,
   input  logic              load,
   input  logic [4*NDIG-1:0] value,
   input  logic [NDIG-1:0]   dp_mask,
   input  logic [NDIG-1:0]   blink_mask,
   input  logic              blank_lz,
   output logic [NDIG-1:0]   led_en,
   output logic [6:0]        led_seg,
   output logic              led_dp,
   output logic              frame_tick
);
   localparam int CW = $clog2(DIV);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic OFF = (ACTIVE_LOW != 0);
   localparam logic INV = (ACTIVE_LOW == 0);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t r_state, w_state_nxt;

   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic              r_shown;
   logic [4*NDIG-1:0] r_pend_val, r_act_val;
   logic [NDIG-1:0]   r_pend_dp, r_pend_blk, r_act_dp, r_act_blk;
   logic              r_pend_flag;
   logic [FW-1:0]     r_frm;
   logic              r_phase;
   logic [NDIG-1:0]   r_en;
   logic [6:0]        r_seg;
   logic              r_dp, r_tick;

   logic              w_run, w_tc, w_bound, w_phase_nxt, w_zero, w_blank, w_dark, w_dp_al;
   logic [IW-1:0]     w_idx_nxt;
   logic [FW-1:0]     w_frm_nxt;
   logic [4*NDIG-1:0] w_act_val;
   logic [NDIG-1:0]   w_act_dp, w_act_blk, w_lz, w_en_al;
   logic [3:0]        w_nib;
   logic [6:0]        w_seg_al;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      unique case (n)
         4'h0: f_decode = 7'b0000001;
         4'h1: f_decode = 7'b1001111;
         4'h2: f_decode = 7'b0010010;
         4'h3: f_decode = 7'b0000110;
         4'h4: f_decode = 7'b1001100;
         4'h5: f_decode = 7'b0100100;
         4'h6: f_decode = 7'b0100000;
         4'h7: f_decode = 7'b0001111;
         4'h8: f_decode = 7'b0000000;
         4'h9: f_decode = 7'b0000100;
         4'hA: f_decode = 7'b0001000;
         4'hB: f_decode = 7'b1100000;
         4'hC: f_decode = 7'b0110001;
         4'hD: f_decode = 7'b1000010;
         4'hE: f_decode = 7'b0110000;
         4'hF: f_decode = 7'b0111000;
      endcase
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_IDLE && start) w_state_nxt = S_RUN;
   end

   always_comb begin
      w_run     = (r_state == S_RUN);
      w_tc      = w_run && (r_cnt == CNT_LAST);
      // Until the first slot has been shown, the first terminal count selects digit 0.
      w_idx_nxt = (!r_shown || r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      w_bound   = w_tc && (w_idx_nxt == '0);

      w_act_val = r_act_val;
      w_act_dp  = r_act_dp;
      w_act_blk = r_act_blk;
      if (load && (!w_run || w_bound)) begin
         w_act_val = value;
         w_act_dp  = dp_mask;
         w_act_blk = blink_mask;
      end else if (w_bound && r_pend_flag) begin
         w_act_val = r_pend_val;
         w_act_dp  = r_pend_dp;
         w_act_blk = r_pend_blk;
      end

      w_frm_nxt   = r_frm;
      w_phase_nxt = r_phase;
      if (w_bound) begin
         if (r_frm == FRM_LAST) begin
            w_frm_nxt   = '0;
            w_phase_nxt = ~r_phase;
         end else begin
            w_frm_nxt = r_frm + FW'(1);
         end
      end
   end

   // Slot contents are decoded from the buffer/phase as they will be after this edge.
   always_comb begin
      w_zero = 1'b1;
      w_lz   = '0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         w_zero  = w_zero && (w_act_val[4*k +: 4] == 4'h0);
         w_lz[k] = w_zero;
      end
      w_nib    = w_act_val[{w_idx_nxt, 2'b00} +: 4];
      w_blank  = blank_lz && (w_idx_nxt != '0) && w_lz[w_idx_nxt];
      w_dark   = w_phase_nxt && w_act_blk[w_idx_nxt];
      w_seg_al = (w_dark || w_blank) ? 7'h7F : f_decode(w_nib);
      w_dp_al  = w_dark ? 1'b1 : ~w_act_dp[w_idx_nxt];
      w_en_al  = ~(NDIG'(1) << w_idx_nxt);
   end

   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shown     <= 1'b0;
         r_pend_val  <= '0;
         r_pend_dp   <= '0;
         r_pend_blk  <= '0;
         r_pend_flag <= 1'b0;
         r_act_val   <= '0;
         r_act_dp    <= '0;
         r_act_blk   <= '0;
         r_frm       <= '0;
         r_phase     <= 1'b0;
         r_en        <= {NDIG{OFF}};
         r_seg       <= {7{OFF}};
         r_dp        <= OFF;
         r_tick      <= 1'b0;
      end else begin
         r_cnt     <= (!w_run || w_tc) ? '0 : r_cnt + CW'(1);
         r_act_val <= w_act_val;
         r_act_dp  <= w_act_dp;
         r_act_blk <= w_act_blk;
         r_frm     <= w_frm_nxt;
         r_phase   <= w_phase_nxt;
         if (load && w_run && !w_bound) begin
            r_pend_val  <= value;
            r_pend_dp   <= dp_mask;
            r_pend_blk  <= blink_mask;
            r_pend_flag <= 1'b1;
         end else if (w_bound) begin
            r_pend_flag <= 1'b0;
         end
         r_tick <= w_bound;
         if (w_tc) begin
            r_idx   <= w_idx_nxt;
            r_shown <= 1'b1;
            r_en    <= w_en_al ^ {NDIG{INV}};
            r_seg   <= w_seg_al ^ {7{INV}};
            r_dp    <= w_dp_al ^ INV;
         end
      end
   end

   assign led_en     = r_en;
   assign led_seg    = r_seg;
   assign led_dp     = r_dp;
   assign frame_tick = r_tick;
endmodule

// File: tb/tb_seg7_scan_display_n.sv
// Bench for seg7_scan_display_n: an active-low and an active-high instance share
// stimulus and are compared every cycle against a time-based reference model.
module tb_seg7_scan_display_n;
   localparam int NDIG  = 4;
   localparam int DIV   = 4;
   localparam int BLINK = 2;

   logic        clk_g = 1'b0, rst_n = 1'b1, start = 1'b0, load = 1'b0, blank_lz = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_mask = '0, blink_mask = '0;
   logic [3:0]  en_l, en_h;
   logic [6:0]  seg_l, seg_h;
   logic        dp_l, dp_h, tk_l, tk_h;
   int          errors = 0, checks = 0;

   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model: time since start, active/pending buffers, expected outputs.
   bit          m_run, m_pf;
   int          m_t;
   logic [15:0] m_val, m_pval;
   logic [3:0]  m_dp, m_pdp, m_bk, m_pbk;
   logic [3:0]  e_en;
   logic [6:0]  e_seg;
   logic        e_dp, e_tick;

   seg7_scan_display_n #(.NDIG(NDIG), .DIV(DIV), .BLINK_FRAMES(BLINK), .ACTIVE_LOW(1)) dut (
      .clk_g(clk_g), .rst_n(rst_n), .start(start), .load(load), .value(value),
      .dp_mask(dp_mask), .blink_mask(blink_mask), .blank_lz(blank_lz),
      .led_en(en_l), .led_seg(seg_l), .led_dp(dp_l), .frame_tick(tk_l));

   seg7_scan_display_n #(.NDIG(NDIG), .DIV(DIV), .BLINK_FRAMES(BLINK), .ACTIVE_LOW(0)) dut_h (
      .clk_g(clk_g), .rst_n(rst_n), .start(start), .load(load), .value(value),
      .dp_mask(dp_mask), .blink_mask(blink_mask), .blank_lz(blank_lz),
      .led_en(en_h), .led_seg(seg_h), .led_dp(dp_h), .frame_tick(tk_h));

   always #5 clk_g = ~clk_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] ie;
      logic [6:0] is;
      logic       id;
      ie = ~e_en;
      is = ~e_seg;
      id = ~e_dp;
      chk({tag, "/en"}, en_l, e_en);
      chk({tag, "/seg"}, seg_l, e_seg);
      chk({tag, "/dp"}, dp_l, e_dp);
      chk({tag, "/tick"}, tk_l, e_tick);
      chk({tag, "/en_h"}, en_h, ie);
      chk({tag, "/seg_h"}, seg_h, is);
      chk({tag, "/dp_h"}, dp_h, id);
      chk({tag, "/tick_h"}, tk_h, e_tick);
   endtask

   task automatic model_reset();
      m_run = 0; m_pf = 0; m_t = 0;
      m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0; m_bk = '0; m_pbk = '0;
      e_en = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
   endtask

   task automatic model_step();
      logic [15:0] sh;
      int          d, n;
      bit          bnd, blank, dark;
      if (!m_run) begin
         if (load) begin m_val = value; m_dp = dp_mask; m_bk = blink_mask; end
         if (start) begin m_run = 1; m_t = 0; end
         e_tick = 1'b0;
         return;
      end
      m_t++;
      bnd = (m_t % DIV == 0) && (((m_t / DIV) - 1) % NDIG == 0);
      if (load && bnd) begin
         m_val = value; m_dp = dp_mask; m_bk = blink_mask; m_pf = 0;
      end else if (load) begin
         m_pval = value; m_pdp = dp_mask; m_pbk = blink_mask; m_pf = 1;
      end else if (bnd && m_pf) begin
         m_val = m_pval; m_dp = m_pdp; m_bk = m_pbk; m_pf = 0;
      end
      if (m_t % DIV == 0) begin
         d = ((m_t / DIV) - 1) % NDIG;
         n = ((m_t / DIV) - 1) / NDIG + 1;
         sh = m_val >> (4 * d);
         blank = blank_lz && (d > 0) && (sh == 16'h0);
         dark = ((n / BLINK) % 2 == 1) && m_bk[d];
         e_seg = (dark || blank) ? 7'h7F : seg_tab[sh[3:0]];
         e_dp = dark ? 1'b1 : ~m_dp[d];
         e_en = 4'hF;
         e_en[d] = 1'b0;
         e_tick = (d == 0);
      end else begin
         e_tick = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk_g);
      model_step();
      #1;
      check_outputs("cyc");
   endtask

   task automatic wait_en(input logic [3:0] tgt, input string tag);
      int n = 0;
      while (e_en !== tgt && n < 100) begin tick(); n++; end
      chk({tag, "/reach"}, {31'b0, e_en === tgt}, 32'd1);
   endtask

   task automatic wait_tick(input string tag);
      int n = 0;
      do begin tick(); n++; end while (e_tick !== 1'b1 && n < 100);
      chk({tag, "/reach"}, {31'b0, e_tick === 1'b1}, 32'd1);
   endtask

   task automatic wait_before_boundary();
      int n = 0;
      while (!(((m_t + 1) % DIV == 0) && ((((m_t + 1) / DIV) - 1) % NDIG == 0)) && n < 100) begin
         tick(); n++;
      end
      chk("bnd/reach", {31'b0, n < 100}, 32'd1);
   endtask

   initial begin
      logic [3:0] slot_en  [4];
      logic [6:0] slot_seg [4];
      slot_en  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      slot_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

      // Reset state
      #1 rst_n = 1'b0;
      #1 model_reset();
      check_outputs("reset");
      chk("reset/en_h_lit", en_h, 4'b0000);
      chk("reset/seg_h_lit", seg_h, 7'b0000000);
      #1 rst_n = 1'b1;

      // Load while idle at edge 1, start sampled at edge 10
      value = 16'h1234; load = 1'b1;
      tick(); load = 1'b0;
      repeat (8) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      chk("e13/en", en_l, 4'b1111);
      chk("e13/seg", seg_l, 7'b1111111);
      for (int s = 0; s < 4; s++) begin
         tick();
         chk("slot/en", en_l, slot_en[s]);
         chk("slot/seg", seg_l, slot_seg[s]);
         chk("slot/tick", tk_l, (s == 0) ? 32'd1 : 32'd0);
         repeat (3) tick();
      end
      tick();
      chk("wrap/en", en_l, 4'b1110);
      chk("wrap/seg", seg_l, 7'b1001100);

      // Tear-free load while digit 2 is active
      wait_en(4'b1011, "tear2");
      value = 16'hABCD; load = 1'b1; tick(); load = 1'b0;
      chk("tear/d2", seg_l, 7'b0010010);
      wait_en(4'b0111, "tear3");
      chk("tear/d3", seg_l, 7'b1001111);
      wait_tick("tear_tick");
      chk("tear/d0", seg_l, 7'b1000010);

      // Leading-zero blanking
      value = 16'h0050; blank_lz = 1'b1; load = 1'b1; tick(); load = 1'b0;
      repeat (20) tick();
      wait_en(4'b0111, "lz3"); chk("lz/d3", seg_l, 7'b1111111);
      wait_en(4'b1011, "lz2"); chk("lz/d2", seg_l, 7'b1111111);
      wait_en(4'b1101, "lz1"); chk("lz/d1", seg_l, 7'b0100100);
      wait_en(4'b1110, "lz0"); chk("lz/d0", seg_l, 7'b0000001);
      blank_lz = 1'b0;
      wait_en(4'b0111, "nlz3"); chk("nlz/d3", seg_l, 7'b0000001);
      wait_en(4'b1011, "nlz2"); chk("nlz/d2", seg_l, 7'b0000001);

      // Decimal point and blink across several frames
      dp_mask = 4'b0010; blink_mask = 4'b0001; load = 1'b1; tick(); load = 1'b0;
      repeat (6 * NDIG * DIV) tick();

      // Load landing exactly on a frame boundary commits directly
      wait_before_boundary();
      value = 16'h7E3C; dp_mask = 4'b0000; blink_mask = 4'b0000; load = 1'b1;
      tick(); load = 1'b0;
      chk("bndload/seg", seg_l, 7'b0110001);

      // Randomized loads, masks and spurious start pulses
      for (int r = 0; r < 12; r++) begin
         logic [15:0] v;
         int nz;
         v = 16'($urandom);
         nz = $urandom_range(0, 3);
         v = v & (16'hFFFF >> (4 * nz));
         value = v; dp_mask = 4'($urandom); blink_mask = 4'($urandom);
         blank_lz = 1'($urandom);
         load = 1'b1; tick(); load = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            value = 16'($urandom); load = 1'b1; tick(); load = 1'b0;
         end
         repeat ($urandom_range(5, 40)) begin
            start = ($urandom_range(0, 7) == 0);
            tick();
         end
         start = 1'b0;
      end

      // Polarity: digit 0 showing '8'
      value = 16'h0008; dp_mask = '0; blink_mask = '0; load = 1'b1; tick(); load = 1'b0;
      wait_tick("pol_tick");
      chk("pol/en_h", en_h, 4'b0001);
      chk("pol/seg_h", seg_h, 7'b1111111);
      chk("pol/seg_l", seg_l, 7'b0000000);

      // Mid-scan reset during slot 2, then restart
      wait_en(4'b1011, "mr2");
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs("midrst");
      #2 rst_n = 1'b1;
      repeat (5) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      chk("rs/off_en", en_l, 4'b1111);
      tick();
      chk("rs/en", en_l, 4'b1110);
      chk("rs/seg", seg_l, 7'b0000001);
      chk("rs/tick", tk_l, 32'd1);
      repeat (2 * NDIG * DIV) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
